lcd_bus_arbiter: RTL and testbench
==================================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 4: the number of idle bus cycles between grants; legal range 1..255.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000: the maximum number of cycles one grant is held; legal range 2..2^20-1.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESETN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port REQ0, input, 1 bit: bus request from requester 0 (font loader).
REQ-006 The block SHALL have port REQ1, input, 1 bit: bus request from requester 1 (text LCD controller).
REQ-007 The block SHALL have ports E0, RS0, RW0, input, 1 bit each: requester 0 LCD control lines.
REQ-008 The block SHALL have port DATA0, input, 8 bits: requester 0 LCD data.
REQ-009 The block SHALL have ports E1, RS1, RW1, input, 1 bit each, and port DATA1, input, 8 bits: requester 1 LCD lines.
REQ-010 The block SHALL have ports GNT0 and GNT1, output, 1 bit each, registered: the grant to each requester.
REQ-011 The block SHALL have ports TLCD_E, TLCD_RS, TLCD_RW, output, 1 bit each, and port TLCD_DATA, output, 8 bits: the shared LCD bus.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port TIMEOUT_ERR, output, 1 bit: a sticky timeout flag.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, GRANT0, GRANT1 and GAP.
REQ-015 In IDLE, when an eligible request is sampled high, the FSM SHALL move to GRANTx, with GNTx high from the next cycle (1-cycle request-to-grant latency).
REQ-016 In IDLE with both requests eligible, default priority SHALL grant requester 0.
REQ-017 GNT0 and GNT1 SHALL never be high in the same cycle.
REQ-018 In GRANTx the FSM SHALL hold while REQx stays high.
REQ-019 In GRANTx, REQx sampled low SHALL move the FSM to GAP, with GNTx low from the next cycle.
REQ-020 The TLCD_* outputs SHALL be a combinational mux of the granted requester's lines, selected by the registered grant.
REQ-021 With no grant, TLCD_E, TLCD_RS and TLCD_RW SHALL be 0 and TLCD_DATA SHALL be 8'h00.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, counted by a gap counter, and then return to IDLE.
REQ-023 Requests arriving or dropping during GAP SHALL be sampled only on return to IDLE.
REQ-024 A hold counter SHALL clear on entry to GRANTx and increment every GRANTx cycle.
REQ-025 If the hold counter reaches TIMEOUT_CYCLES-1 with REQx still high, the grant SHALL be revoked and the FSM SHALL enter GAP.
REQ-026 On such a revoke, TIMEOUT_ERR SHALL set and stay high until reset, and requester x SHALL be locked out.
REQ-027 A locked-out requester SHALL be ineligible until its REQ is sampled low, which clears the lockout.
REQ-028 A REQx deassertion in the same cycle as the timeout SHALL count as a normal release, with no error and no lockout.
REQ-029 In IDLE with no eligible request, the FSM SHALL stay in IDLE with no grant.

Reset
REQ-030 Asserting RESETN low SHALL immediately force IDLE, zero both counters, clear both lockouts and clear last_grant to 1.
REQ-031 During reset, GNT0, GNT1, BUSY, TIMEOUT_ERR and all TLCD_* outputs SHALL be 0.
REQ-032 A reset taken mid-grant SHALL abort the transfer with no gap cycles.
REQ-033 The first grant after reset release SHALL follow the normal IDLE rules, at the earliest 1 cycle after the first rising edge with RESETN high.

Configuration
REQ-034 With macro ARB_ROUND_ROBIN_EN defined, the block SHALL keep a last_grant register, updated on each grant.
REQ-035 With ARB_ROUND_ROBIN_EN defined and both requests eligible in IDLE, the requester not in last_grant SHALL win; the first contention after reset grants 0.
REQ-036 Without ARB_ROUND_ROBIN_EN, fixed priority to requester 0 SHALL apply and last_grant SHALL not be built.

Verification (bench with GAP_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-037 REQ0 high for 10 cycles, then low -> GNT0 high 1 cycle after REQ0; TLCD_DATA equals DATA0=8'h38 while granted; GNT0 low 1 cycle after REQ0 falls; BUSY high for exactly 4 further cycles.
REQ-038 REQ0 and REQ1 rise in the same cycle, each releasing after 5 granted cycles -> fixed priority: GNT0 first, then GNT1 exactly 4 gap cycles after GNT0 falls, and never both high.
REQ-039 Under ARB_ROUND_ROBIN_EN, both requests held continuously and each released after 3 granted cycles, then re-raised -> grants alternate 0,1,0,1.
REQ-040 REQ1 held high for 40 cycles -> GNT1 revoked after 16 granted cycles; TIMEOUT_ERR=1; REQ1 not regranted until it goes low and then high again; TIMEOUT_ERR stays 1.
REQ-041 RESETN pulsed low during GRANT0, mid-transfer -> GNT0=0, TLCD_E=0 and BUSY=0 immediately, asynchronously; with REQ0 still high, GNT0 returns 1 cycle after the first rising edge with RESETN high.

Source files
------------

// File: rtl/lcd_bus_arbiter_if.sv
// Shared-LCD arbitration bundle: two requesters' request/LCD lines in,
// grants, the muxed LCD bus and status out.
//   master : requester side (drives REQx and LCD lines, observes grants/bus/status)
//   slave  : arbiter side   (observes requests/lines, drives grants/bus/status)
interface lcd_bus_arbiter_if;
    logic       REQ0;
    logic       REQ1;
    logic       E0;
    logic       RS0;
    logic       RW0;
    logic [7:0] DATA0;
    logic       E1;
    logic       RS1;
    logic       RW1;
    logic [7:0] DATA1;
    logic       GNT0;
    logic       GNT1;
    logic       TLCD_E;
    logic       TLCD_RS;
    logic       TLCD_RW;
    logic [7:0] TLCD_DATA;
    logic       BUSY;
    logic       TIMEOUT_ERR;

    modport master (
        output REQ0, REQ1, E0, RS0, RW0, DATA0, E1, RS1, RW1, DATA1,
        input  GNT0, GNT1, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA, BUSY, TIMEOUT_ERR
    );

    modport slave (
        input  REQ0, REQ1, E0, RS0, RW0, DATA0, E1, RS1, RW1, DATA1,
        output GNT0, GNT1, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA, BUSY, TIMEOUT_ERR
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for a shared character-LCD bus.
// Grants one requester at a time, holds while its request stays high, then
// inserts GAP_CYCLES idle cycles before the next grant. A grant held for
// TIMEOUT_CYCLES cycles is revoked, sets a sticky TIMEOUT_ERR and locks that
// requester out until it drops its request.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin on contention
// (default build: fixed priority to requester 0).
// Ports:
//   CLK    : clock, rising edge
//   RESETN : asynchronous active-low reset
//   bus    : lcd_bus_arbiter_if.slave (REQx, Ex/RSx/RWx/DATAx in;
//            GNTx, TLCD_*, BUSY, TIMEOUT_ERR out)
module lcd_bus_arbiter #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic              CLK,
    input logic              RESETN,
    lcd_bus_arbiter_if.slave bus
);
    localparam int unsigned      HoldW    = 20;
    localparam int unsigned      GapW     = 8;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(TIMEOUT_CYCLES - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StGap} state_e;

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             lock0_q, lock0_d;
    logic             lock1_q, lock1_d;
    logic             err_q, err_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             elig0, elig1;
`ifdef ARB_ROUND_ROBIN_EN
    logic             last_q, last_d;  // requester that won the most recent grant
`endif

    assign elig0 = bus.REQ0 & ~lock0_q;
    assign elig1 = bus.REQ1 & ~lock1_q;

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        gap_d   = '0;
        // A lockout lasts until the locked requester is seen with REQ low.
        lock0_d = lock0_q & bus.REQ0;
        lock1_d = lock1_q & bus.REQ1;
        err_d   = err_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (elig0 && elig1) begin
                    state_d = last_q ? StGrant0 : StGrant1;
                    last_d  = ~last_q;
                end else if (elig0) begin
                    state_d = StGrant0;
                    last_d  = 1'b0;
                end else if (elig1) begin
                    state_d = StGrant1;
                    last_d  = 1'b1;
                end
`else
                if (elig0) begin
                    state_d = StGrant0;
                end else if (elig1) begin
                    state_d = StGrant1;
                end
`endif
            end
            StGrant0: begin
                // Release wins over timeout when both happen in the same cycle.
                if (!bus.REQ0) begin
                    state_d = StGap;
                end else if (hold_q == HoldLast) begin
                    state_d = StGap;
                    lock0_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StGrant1: begin
                if (!bus.REQ1) begin
                    state_d = StGap;
                end else if (hold_q == HoldLast) begin
                    state_d = StGap;
                    lock1_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        gnt0_d = (state_d == StGrant0);
        gnt1_d = (state_d == StGrant1);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= StIdle;
            hold_q  <= '0;
            gap_q   <= '0;
            lock0_q <= 1'b0;
            lock1_q <= 1'b0;
            err_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            lock0_q <= lock0_d;
            lock1_q <= lock1_d;
            err_q   <= err_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset to 1 so the first contention goes to requester 0.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.GNT0        = gnt0_q;
    assign bus.GNT1        = gnt1_q;
    assign bus.BUSY        = (state_q != StIdle);
    assign bus.TIMEOUT_ERR = err_q;

    // Bus mux keyed on the registered grants; parked at zero with no grant.
    always_comb begin
        bus.TLCD_E    = 1'b0;
        bus.TLCD_RS   = 1'b0;
        bus.TLCD_RW   = 1'b0;
        bus.TLCD_DATA = 8'h00;
        if (gnt0_q) begin
            bus.TLCD_E    = bus.E0;
            bus.TLCD_RS   = bus.RS0;
            bus.TLCD_RW   = bus.RW0;
            bus.TLCD_DATA = bus.DATA0;
        end else if (gnt1_q) begin
            bus.TLCD_E    = bus.E1;
            bus.TLCD_RS   = bus.RS1;
            bus.TLCD_RW   = bus.RW1;
            bus.TLCD_DATA = bus.DATA1;
        end
    end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
`timescale 1ns/1ps
module tb_lcd_bus_arbiter;
    localparam int GAP = 4;
    localparam int TMO = 16;

    logic CLK    = 1'b0;
    logic RESETN = 1'b1;

    lcd_bus_arbiter_if bus ();

    lcd_bus_arbiter #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK   (CLK),
        .RESETN(RESETN),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // Reference model: who owns the bus, how many granted cycles have elapsed,
    // how many gap cycles remain, lockouts, sticky error, last winner.
    typedef struct packed {
        int         owner;  // -1 none, else requester index
        int         held;   // granted cycles already completed
        int         gap;    // gap cycles remaining
        logic [1:0] lock;
        logic       err;
        logic       last;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.owner = -1;
        r.held  = 0;
        r.gap   = 0;
        r.lock  = 2'b00;
        r.err   = 1'b0;
        r.last  = 1'b1;
        return r;
    endfunction

    function automatic model_t model_step(model_t s, logic [1:0] rq);
        model_t     n = s;
        logic [1:0] elig;
        n.lock = s.lock & rq;
        if (s.owner >= 0) begin
            if (!rq[s.owner]) begin
                n.owner = -1;
                n.held  = 0;
                n.gap   = GAP;
            end else if (s.held + 1 == TMO) begin
                n.lock[s.owner] = 1'b1;
                n.err   = 1'b1;
                n.owner = -1;
                n.held  = 0;
                n.gap   = GAP;
            end else begin
                n.held = s.held + 1;
            end
        end else if (s.gap > 0) begin
            n.gap = s.gap - 1;
        end else begin
            elig = rq & ~s.lock;
            if (elig == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
                n.owner = s.last ? 0 : 1;
`else
                n.owner = 0;
`endif
            end else if (elig[0]) begin
                n.owner = 0;
            end else if (elig[1]) begin
                n.owner = 1;
            end
            if (n.owner >= 0) begin
                n.held = 0;
                n.last = (n.owner == 1);
            end
        end
        return n;
    endfunction

    function automatic logic [14:0] model_out(model_t s);
        logic [10:0] lines;
        lines = '0;
        if (s.owner == 0) lines = {bus.E0, bus.RS0, bus.RW0, bus.DATA0};
        else if (s.owner == 1) lines = {bus.E1, bus.RS1, bus.RW1, bus.DATA1};
        return {s.owner == 0, s.owner == 1, (s.owner >= 0) || (s.gap > 0), s.err, lines};
    endfunction

    function automatic logic [14:0] dut_out();
        return {bus.GNT0, bus.GNT1, bus.BUSY, bus.TIMEOUT_ERR,
                bus.TLCD_E, bus.TLCD_RS, bus.TLCD_RW, bus.TLCD_DATA};
    endfunction

    initial begin
        m = model_reset();
        forever begin
            @(posedge CLK or negedge RESETN);
            if (!RESETN) m = model_reset();
            else m = model_step(m, {bus.REQ1, bus.REQ0});
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (cmp_en) begin
                n_tests++;
                if (dut_out() !== model_out(m)) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t got {g0,g1,busy,err,e,rs,rw,data}=%h expected %h",
                             $time, dut_out(), model_out(m));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int who);
        int k = 0;
        who = -1;
        while (!(bus.GNT0 || bus.GNT1) && k < 20) begin
            tick();
            k++;
        end
        if (bus.GNT0) who = 0;
        else if (bus.GNT1) who = 1;
        else begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_grant: got no grant in 20 cycles expected a grant");
        end
    endtask

    task automatic drain();
        repeat (GAP + 2) tick();
        check("drain_idle", bus.BUSY, 0);
    endtask

    int cnt;
    int who;
    int exp_seq[4];

    initial begin
        bus.REQ0 = 0; bus.REQ1 = 0;
        bus.E0 = 1; bus.RS0 = 1; bus.RW0 = 0; bus.DATA0 = 8'h38;
        bus.E1 = 1; bus.RS1 = 0; bus.RW1 = 1; bus.DATA1 = 8'hA5;

        #1 RESETN = 1'b0;
        #1;
        check("reset_outputs", dut_out(), 0);
        tick();
        tick();
        RESETN = 1'b1;
        cmp_en = 1'b1;
        tick();
        check("idle_no_grant", {bus.GNT0, bus.GNT1, bus.BUSY}, 0);

        // Single requester: 10-cycle request, then 4 busy gap cycles.
        bus.REQ0 = 1;
        tick();
        check("a_gnt0_latency", bus.GNT0, 1);
        check("a_gnt1_low", bus.GNT1, 0);
        check("a_tlcd_data", bus.TLCD_DATA, 8'h38);
        repeat (9) tick();
        check("a_gnt0_held", bus.GNT0, 1);
        bus.REQ0 = 0;
        tick();
        check("a_gnt0_release", bus.GNT0, 0);
        check("a_gap1_busy", bus.BUSY, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("a_gap_busy", bus.BUSY, 1);
        end
        tick();
        check("a_gap_end", bus.BUSY, 0);

        // Simultaneous requests, fixed priority, 5 granted cycles each.
        bus.REQ0 = 1; bus.REQ1 = 1;
        tick();
        check("b_gnt0_first", {bus.GNT0, bus.GNT1}, 2'b10);
        repeat (4) tick();
        bus.REQ0 = 0;
        tick();
        check("b_gnt0_drop", bus.GNT0, 0);
        cnt = 0;
        while (!bus.GNT1 && cnt < 20) begin
            tick();
            cnt++;
        end
        check("b_gnt1_spacing", cnt, GAP + 1);
        check("b_tlcd_data1", bus.TLCD_DATA, 8'hA5);
        repeat (4) tick();
        bus.REQ1 = 0;
        tick();
        check("b_gnt1_drop", bus.GNT1, 0);
        repeat (GAP) tick();
        check("b_idle", bus.BUSY, 0);

        // Release coinciding with the timeout cycle is a normal release.
        bus.REQ0 = 1;
        tick();
        repeat (TMO - 1) tick();
        check("t_gnt0_last_cycle", bus.GNT0, 1);
        bus.REQ0 = 0;
        tick();
        check("t_release_no_err", {bus.GNT0, bus.TIMEOUT_ERR}, 0);
        drain();
        bus.REQ0 = 1;
        tick();
        check("t_no_lockout", bus.GNT0, 1);
        bus.REQ0 = 0;
        tick();
        drain();

        // Timeout: REQ1 held for 40 cycles.
        bus.REQ1 = 1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.GNT1) cnt++;
        end
        check("c_granted_cycles", cnt, TMO);
        check("c_timeout_err", bus.TIMEOUT_ERR, 1);
        check("c_locked_out", bus.GNT1, 0);
        bus.REQ1 = 0;
        tick();
        bus.REQ1 = 1;
        tick();
        check("c_regrant", bus.GNT1, 1);
        check("c_err_sticky", bus.TIMEOUT_ERR, 1);
        bus.REQ1 = 0;
        tick();
        drain();

        // Asynchronous reset mid-grant.
        bus.REQ0 = 1;
        tick();
        tick();
        check("d_pre_reset_gnt0", bus.GNT0, 1);
        #1 RESETN = 1'b0;
        #1;
        check("d_async_clear", {bus.GNT0, bus.TLCD_E, bus.BUSY, bus.TIMEOUT_ERR}, 0);
        tick();
        RESETN = 1'b1;
        #1;
        check("d_still_low", bus.GNT0, 0);
        tick();
        check("d_regrant_after_reset", bus.GNT0, 1);
        bus.REQ0 = 0;
        tick();
        drain();

        // Continuous contention: each winner releases after 3 cycles and re-raises.
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        bus.REQ0 = 1; bus.REQ1 = 1;
        for (int n = 0; n < 4; n++) begin
            wait_grant(who);
            check("e_grant_order", who, exp_seq[n]);
            repeat (2) tick();
            if (who == 0) bus.REQ0 = 0;
            else if (who == 1) bus.REQ1 = 0;
            tick();
            bus.REQ0 = 1; bus.REQ1 = 1;
        end
        bus.REQ0 = 0; bus.REQ1 = 0;
        tick();
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) bus.REQ0 = ~bus.REQ0;
            if ($urandom_range(0, 13) == 0) bus.REQ1 = ~bus.REQ1;
            {bus.E0, bus.RS0, bus.RW0, bus.DATA0} = 11'($urandom);
            {bus.E1, bus.RS1, bus.RW1, bus.DATA1} = 11'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #1 RESETN = 1'b0;
                tick();
                RESETN = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
